// File: rtl/sampler_axil_reg_bridge.sv
// AXI4-Lite slave that drives the sampler register bus: single-cycle writes and registered reads,
// one outstanding transaction per direction, with write and read channels fully independent.
module sampler_axil_reg_bridge #(
  parameter int ADDR_WIDTH     = 12,
  parameter int REG_ADDR_WIDTH = 10
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_wr,
  output logic [31:0]               data_in,
  output logic [3:0]                byte_enable,
  output logic                      data_wren,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_rd,
  input  logic [31:0]               data_out
);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  // Any byte-address bit above the register window marks the access as out of range.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (REG_ADDR_WIDTH + 2)) != '0;
  endfunction

  wstate_t                   wstate_q, wstate_d;
  logic                      aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]     awaddr_buf_q, awaddr_buf_d;
  logic [31:0]               wdata_buf_q, wdata_buf_d;
  logic [3:0]                wstrb_buf_q, wstrb_buf_d;
  logic                      awready_q, awready_d, wready_q, wready_d;
  logic                      bvalid_q, bvalid_d, data_wren_q, data_wren_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_wr_q, reg_addr_wr_d;
  logic [31:0]               data_in_q, data_in_d;
  logic [3:0]                byte_enable_q, byte_enable_d;

  rstate_t                   rstate_q, rstate_d;
  logic                      ar_err_q, ar_err_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_rd_q, reg_addr_rd_d;

  always_comb begin
    wstate_d      = wstate_q;
    aw_full_d     = aw_full_q;
    w_full_d      = w_full_q;
    awaddr_buf_d  = awaddr_buf_q;
    wdata_buf_d   = wdata_buf_q;
    wstrb_buf_d   = wstrb_buf_q;
    bresp_d       = bresp_q;
    reg_addr_wr_d = reg_addr_wr_q;
    data_in_d     = data_in_q;
    byte_enable_d = byte_enable_q;
    data_wren_d   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (s_axil_awvalid && awready_q) begin
          aw_full_d    = 1'b1;
          awaddr_buf_d = s_axil_awaddr;
        end
        if (s_axil_wvalid && wready_q) begin
          w_full_d    = 1'b1;
          wdata_buf_d = s_axil_wdata;
          wstrb_buf_d = s_axil_wstrb;
        end
        // The register-bus write is launched from the registers so it lands one cycle after capture.
        if (aw_full_d && w_full_d) begin
          wstate_d      = W_WRITE;
          data_wren_d   = !addr_err(awaddr_buf_d);
          bresp_d       = addr_err(awaddr_buf_d) ? 2'b10 : 2'b00;
          reg_addr_wr_d = awaddr_buf_d[REG_ADDR_WIDTH+1:2];
          data_in_d     = wdata_buf_d;
          byte_enable_d = wstrb_buf_d;
        end
      end
      W_WRITE: wstate_d = W_RESP;
      W_RESP: begin
        if (s_axil_bready) begin
          wstate_d  = W_IDLE;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_full_d;
    wready_d  = (wstate_d == W_IDLE) && !w_full_d;
    bvalid_d  = (wstate_d == W_RESP);
  end

  always_comb begin
    rstate_d      = rstate_q;
    ar_err_d      = ar_err_q;
    reg_addr_rd_d = reg_addr_rd_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axil_arvalid && arready_q) begin
          rstate_d      = R_ADDR;
          reg_addr_rd_d = s_axil_araddr[REG_ADDR_WIDTH+1:2];
          ar_err_d      = addr_err(s_axil_araddr);
        end
      end
      R_ADDR: begin
        rstate_d = R_DATA;
        rdata_d  = ar_err_q ? 32'h0 : data_out;
        rresp_d  = ar_err_q ? 2'b10 : 2'b00;
      end
      R_DATA: if (s_axil_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      wstate_q      <= W_IDLE;
      aw_full_q     <= 1'b0;
      w_full_q      <= 1'b0;
      awaddr_buf_q  <= '0;
      wdata_buf_q   <= '0;
      wstrb_buf_q   <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      data_wren_q   <= 1'b0;
      reg_addr_wr_q <= '0;
      data_in_q     <= '0;
      byte_enable_q <= '0;
      rstate_q      <= R_IDLE;
      ar_err_q      <= 1'b0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      reg_addr_rd_q <= '0;
    end else begin
      wstate_q      <= wstate_d;
      aw_full_q     <= aw_full_d;
      w_full_q      <= w_full_d;
      awaddr_buf_q  <= awaddr_buf_d;
      wdata_buf_q   <= wdata_buf_d;
      wstrb_buf_q   <= wstrb_buf_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      data_wren_q   <= data_wren_d;
      reg_addr_wr_q <= reg_addr_wr_d;
      data_in_q     <= data_in_d;
      byte_enable_q <= byte_enable_d;
      rstate_q      <= rstate_d;
      ar_err_q      <= ar_err_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      reg_addr_rd_q <= reg_addr_rd_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign data_wren      = data_wren_q;
  assign reg_addr_wr    = reg_addr_wr_q;
  assign data_in        = data_in_q;
  assign byte_enable    = byte_enable_q;
  assign reg_addr_rd    = reg_addr_rd_q;

endmodule

// File: tb/tb_sampler_axil_reg_bridge.sv
// Directed bench for sampler_axil_reg_bridge with a small register-file model on the register bus.
module tb_sampler_axil_reg_bridge;
  localparam int AW = 16;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          axi_reset;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid, data_wren;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata, data_in, data_out;
  logic [3:0]    byte_enable;
  logic [RW-1:0] reg_addr_wr, reg_addr_rd;

  bit [31:0] mem [1024];
  int        wren_cnt = 0;
  int        n_chk = 0;
  int        n_pass = 0;

  always #5 clk = ~clk;

  sampler_axil_reg_bridge #(.ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_addr_wr(reg_addr_wr), .data_in(data_in), .byte_enable(byte_enable), .data_wren(data_wren),
    .reg_addr_rd(reg_addr_rd), .data_out(data_out)
  );

  // Fixed ID/capability words at 0x000, 0x004 and 0x020; everything else is plain storage.
  assign data_out = (reg_addr_rd == 10'd0) ? 32'h0000_0001 :
                    (reg_addr_rd == 10'd1) ? 32'h0000_0004 :
                    (reg_addr_rd == 10'd8) ? 32'hbeef_dead : mem[reg_addr_rd];

  always @(posedge clk) begin
    if (data_wren) begin
      wren_cnt <= wren_cnt + 1;
      for (int i = 0; i < 4; i++)
        if (byte_enable[i]) mem[reg_addr_wr][8*i +: 8] <= data_in[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    chk("rd_arready_pre", arready, 1);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rd_rvalid_c1", rvalid, 0);
    chk("rd_reg_addr", reg_addr_rd, a[RW+1:2]);
    step();
    chk("rd_rvalid_c2", rvalid, 1);
    chk("rd_rdata", rdata, exp_d);
    chk("rd_rresp", rresp, exp_r);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rd_rvalid_done", rvalid, 0);
    chk("rd_arready_done", arready, 1);
  endtask

  task automatic b_handshake();
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("b_bvalid_done", bvalid, 0);
    chk("b_awready_done", awready, 1);
  endtask

  initial begin
    axi_reset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    step(); step();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wren", data_wren, 0);
    chk("rst_rdata", rdata, 0);
    axi_reset = 1'b0;
    step();
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    // AW and W together
    awaddr = 16'h0040; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_wren", data_wren, 1);
    chk("t1_addr", reg_addr_wr, 10'h010);
    chk("t1_data", data_in, 32'h1234_5678);
    chk("t1_be", byte_enable, 4'hF);
    chk("t1_bvalid_c1", bvalid, 0);
    step();
    chk("t1_wren_off", data_wren, 0);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 0);
    b_handshake();
    chk("t1_wren_cnt", wren_cnt, 1);
    do_read(16'h0040, 32'h1234_5678, 2'b00);
    do_read(16'h0000, 32'h0000_0001, 2'b00);
    do_read(16'h0004, 32'h0000_0004, 2'b00);
    do_read(16'h0020, 32'hbeef_dead, 2'b00);
    do_read(16'h0043, 32'h1234_5678, 2'b00);

    // W three cycles ahead of AW
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("t2_wready_drop", wready, 0);
    chk("t2_awready", awready, 1);
    step(); step();
    chk("t2_no_wren", data_wren, 0);
    chk("t2_wready_held", wready, 0);
    awaddr = 16'h0044; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("t2_wren", data_wren, 1);
    chk("t2_addr", reg_addr_wr, 10'h011);
    chk("t2_data", data_in, 32'hA5A5_A5A5);
    step();
    chk("t2_bvalid", bvalid, 1);
    b_handshake();
    chk("t2_wren_cnt", wren_cnt, 2);
    do_read(16'h0044, 32'hA5A5_A5A5, 2'b00);

    // Out-of-range write and read
    awaddr = 16'h1040; awvalid = 1'b1; wdata = 32'hDEAD_0000; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("err_no_wren", data_wren, 0);
    step();
    chk("err_bvalid", bvalid, 1);
    chk("err_bresp", bresp, 2'b10);
    b_handshake();
    chk("err_wren_cnt", wren_cnt, 2);
    do_read(16'h1000, 32'h0, 2'b10);
    do_read(16'h0040, 32'h1234_5678, 2'b00);

    // Read coinciding with a write to the same register sees the old value
    awaddr = 16'h0050; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'h3; wvalid = 1'b1;
    araddr = 16'h0050; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("co_wren", data_wren, 1);
    chk("co_rvalid_c1", rvalid, 0);
    step();
    chk("co_bvalid", bvalid, 1);
    chk("co_rvalid", rvalid, 1);
    chk("co_rdata_old", rdata, 32'h0);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    chk("co_done", {bvalid, rvalid}, 2'b00);
    do_read(16'h0050, 32'h0000_F00D, 2'b00);

    // Backpressure on both response channels
    awaddr = 16'h0048; awvalid = 1'b1; wdata = 32'h0000_0011; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 16'h0004; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    step();
    awaddr = 16'h004C; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid", bvalid, 1);
      chk("bp_rvalid", rvalid, 1);
      chk("bp_bresp", bresp, 0);
      chk("bp_rdata", rdata, 32'h0000_0004);
      chk("bp_readies", {awready, wready, arready}, 3'b000);
    end
    chk("bp_wren_cnt", wren_cnt, 4);
    bready = 1'b1;
    step();
    bready = 1'b0; awvalid = 1'b0;
    chk("bp_bvalid_done", bvalid, 0);
    chk("bp_awready_back", awready, 1);
    chk("bp_rvalid_still", rvalid, 1);
    step();
    chk("bp_aw_not_taken", awready, 1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("bp_rvalid_done", rvalid, 0);
    chk("bp_arready_back", arready, 1);

    // Reset during W_RESP
    awaddr = 16'h0054; awvalid = 1'b1; wdata = 32'h0000_0077; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("rw_bvalid_pre", bvalid, 1);
    axi_reset = 1'b1;
    step();
    chk("rw_bvalid", bvalid, 0);
    chk("rw_readies", {awready, wready, arready}, 3'b000);
    chk("rw_wren", data_wren, 0);
    chk("rw_addr", reg_addr_wr, 0);
    chk("rw_data", data_in, 0);
    chk("rw_be", byte_enable, 0);
    axi_reset = 1'b0;
    step();
    chk("rw_idle", {awready, wready, arready, bvalid}, 4'b1110);

    // Reset during R_ADDR
    araddr = 16'h0004; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    axi_reset = 1'b1;
    step();
    chk("rr_rvalid", rvalid, 0);
    chk("rr_rdata", rdata, 0);
    chk("rr_addr", reg_addr_rd, 0);
    chk("rr_arready", arready, 0);
    axi_reset = 1'b0;
    step(); step();
    chk("rr_no_stale", rvalid, 0);
    chk("rr_arready_back", arready, 1);
    chk("final_wren_cnt", wren_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
